// File: rtl/cs_rr_arbiter.sv
// cs_rr_arbiter: round-robin arbiter in front of a 74x138-style 3-to-8
// chip-select decoder. Eight level requesters share the decoder; the winner
// drives sel/dec_en and a matching active-low one-hot grant vector. A dead
// gap of GAP_CYCLES disabled cycles separates any two grants.
//
// Optional feature macro: CS_HOLD_TIMEOUT_EN
//   defined   -> grants are revoked after MAX_HOLD cycles (hold_timeout pulses)
//   undefined -> a grant lasts as long as its request stays high
//
// Handshake: req is a plain level request. A requester owns the decoder from
// the cycle its gnt_n bit goes low until it drops req (or is timed out); it
// must not assume ownership in any cycle where its gnt_n bit is high.
module cs_rr_arbiter #(
  parameter int GAP_CYCLES = 1,
  parameter int MAX_HOLD   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [2:0] sel,
  output logic       dec_en,
  output logic [7:0] gnt_n,
  output logic       busy,
  output logic       hold_timeout
);

  // Reject out-of-range configurations at elaboration time.
  if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
    $error("cs_rr_arbiter: GAP_CYCLES must be in 1..15");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("cs_rr_arbiter: MAX_HOLD must be in 2..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [3:0] LP_GAP_LOAD = 4'(GAP_CYCLES - 1);

  state_t     r_state;
  logic [2:0] r_sel;
  logic [2:0] r_last;
  logic       r_dec_en;
  logic [7:0] r_gnt_n;
  logic       r_busy;
  logic       r_hold_timeout;
  logic [3:0] r_gap_cnt;

  logic       w_win_found;
  logic [2:0] w_win_idx;
  logic       w_owner_req;
  logic       w_timeout;

`ifdef CS_HOLD_TIMEOUT_EN
  localparam logic [7:0] LP_HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] r_hold_cnt;
`endif

  // Round-robin search: start just after the last winner, wrap upward.
  always_comb begin
    logic [2:0] v_idx;
    w_win_found = 1'b0;
    w_win_idx   = 3'd0;
    v_idx       = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      v_idx = r_last + 3'(k);
      if (!w_win_found && req[v_idx]) begin
        w_win_found = 1'b1;
        w_win_idx   = v_idx;
      end
    end
  end

  // Release conditions for the current owner.
  always_comb begin
    w_owner_req = req[r_sel];
`ifdef CS_HOLD_TIMEOUT_EN
    w_timeout   = (r_hold_cnt == LP_HOLD_LAST);
`else
    w_timeout   = 1'b0;
`endif
  end

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_sel          <= 3'd0;
      r_last         <= 3'd7;
      r_dec_en       <= 1'b0;
      r_gnt_n        <= 8'hFF;
      r_busy         <= 1'b0;
      r_hold_timeout <= 1'b0;
      r_gap_cnt      <= 4'd0;
`ifdef CS_HOLD_TIMEOUT_EN
      r_hold_cnt     <= 8'd0;
`endif
    end else begin
      r_hold_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_win_found) begin
            r_state  <= ST_GRANT;
            r_sel    <= w_win_idx;
            r_last   <= w_win_idx;
            r_dec_en <= 1'b1;
            r_gnt_n  <= ~(8'h01 << w_win_idx);
            r_busy   <= 1'b1;
`ifdef CS_HOLD_TIMEOUT_EN
            r_hold_cnt <= 8'd0;
`endif
          end
        end
        ST_GRANT: begin
          if (!w_owner_req || w_timeout) begin
            // A plain drop wins over a timeout in the same cycle.
            r_state        <= ST_GAP;
            r_dec_en       <= 1'b0;
            r_gnt_n        <= 8'hFF;
            r_gap_cnt      <= LP_GAP_LOAD;
            r_hold_timeout <= w_owner_req & w_timeout;
          end else begin
`ifdef CS_HOLD_TIMEOUT_EN
            r_hold_cnt <= r_hold_cnt + 8'd1;
`endif
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == 4'd0) begin
            if (w_win_found) begin
              r_state  <= ST_GRANT;
              r_sel    <= w_win_idx;
              r_last   <= w_win_idx;
              r_dec_en <= 1'b1;
              r_gnt_n  <= ~(8'h01 << w_win_idx);
`ifdef CS_HOLD_TIMEOUT_EN
              r_hold_cnt <= 8'd0;
`endif
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_dec_en <= 1'b0;
          r_gnt_n  <= 8'hFF;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign sel          = r_sel;
  assign dec_en       = r_dec_en;
  assign gnt_n        = r_gnt_n;
  assign busy         = r_busy;
  assign hold_timeout = r_hold_timeout;

endmodule

// File: tb/tb_cs_rr_arbiter.sv
// tb_cs_rr_arbiter: directed scenarios plus randomized traffic for
// cs_rr_arbiter, checked every cycle against a transaction-level model of
// the arbitration rules (owner / dead-time / last-winner bookkeeping).
module tb_cs_rr_arbiter;

  localparam int GAP = 1;
  localparam int HOLD = 16;
`ifdef CS_HOLD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [2:0] sel;
  logic       dec_en;
  logic [7:0] gnt_n;
  logic       busy;
  logic       hold_timeout;

  always #5 clk = ~clk;

  cs_rr_arbiter #(.GAP_CYCLES(GAP), .MAX_HOLD(HOLD)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .sel          (sel),
    .dec_en       (dec_en),
    .gnt_n        (gnt_n),
    .busy         (busy),
    .hold_timeout (hold_timeout)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: current grant holder or -1; dead: disabled cycles still to run
  // after a release; last: most recent winner; hold: completed grant cycles.
  int m_owner = -1;
  int m_dead  = 0;
  int m_last  = 7;
  int m_sel   = 0;
  int m_hold  = 0;
  bit m_to    = 1'b0;

  function automatic int pick(input logic [7:0] r, input int last);
    for (int k = 1; k <= 8; k++) begin
      if (r[(last + k) % 8]) return (last + k) % 8;
    end
    return -1;
  endfunction

  function automatic void model_step(input logic [7:0] r, input logic rs);
    int w;
    m_to = 1'b0;
    if (rs) begin
      m_owner = -1; m_dead = 0; m_last = 7; m_sel = 0; m_hold = 0;
    end else if (m_owner >= 0) begin
      m_hold++;
      if (!r[m_owner]) begin
        m_owner = -1; m_dead = GAP;
      end else if (TO_EN && m_hold >= HOLD) begin
        m_owner = -1; m_dead = GAP; m_to = 1'b1;
      end
    end else if (m_dead > 1) begin
      m_dead--;
    end else begin
      m_dead = 0;
      w = pick(r, m_last);
      if (w >= 0) begin
        m_owner = w; m_sel = w; m_last = w; m_hold = 0;
      end
    end
  endfunction

  // ---------------- driver ----------------
  logic       p_dec_en = 1'b0;
  logic [2:0] p_sel    = 3'd0;

  task automatic compare_all();
    logic [7:0] e_gnt;
    e_gnt = 8'hFF;
    if (m_owner >= 0) e_gnt[m_owner] = 1'b0;
    check_value("sel", 32'(sel), 32'(m_sel));
    check_value("dec_en", 32'(dec_en), 32'(m_owner >= 0));
    check_value("gnt_n", 32'(gnt_n), 32'(e_gnt));
    check_value("busy", 32'(busy), 32'((m_owner >= 0) || (m_dead > 0)));
    check_value("hold_timeout", 32'(hold_timeout), 32'(m_to));
    check_value("gnt_onehot", 32'($countones(~gnt_n) <= 1), 32'd1);
    if (p_dec_en && dec_en) check_value("sel_stable", 32'(sel), 32'(p_sel));
    p_dec_en = dec_en;
    p_sel    = sel;
  endtask

  // Drive one cycle: inputs set after the falling edge, outputs sampled at
  // the next falling edge.
  task automatic cycle(input logic [7:0] r, input logic rs);
    req = r;
    rst = rs;
    @(posedge clk);
    model_step(r, rs);
    @(negedge clk);
    compare_all();
  endtask

  // Drop all requests long enough to pass any gap and return to idle.
  task automatic drain();
    repeat (GAP + 1) cycle(8'h00, 1'b0);
    check_value("drain_idle", 32'(busy), 32'd0);
  endtask

  function automatic int owner_of(input logic [7:0] g);
    for (int i = 0; i < 8; i++) if (!g[i]) return i;
    return -1;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int to_pulses;
    int grants;
    int dis_cycles;
    int budget;
    logic [7:0] r;

    req = 8'h00;
    rst = 1'b1;
    @(negedge clk);

    // 1. reset with all requests high
    cycle(8'hFF, 1'b1);
    cycle(8'hFF, 1'b1);
    check_value("rst_sel", 32'(sel), 32'd0);
    check_value("rst_dec_en", 32'(dec_en), 32'd0);
    check_value("rst_gnt_n", 32'(gnt_n), 32'hFF);
    check_value("rst_busy", 32'(busy), 32'd0);
    cycle(8'hFF, 1'b0);
    check_value("first_grant", 32'(gnt_n), 32'hFE);
    drain();

    // 2. single request, release and gap
    cycle(8'h08, 1'b0);
    check_value("single_sel", 32'(sel), 32'd3);
    check_value("single_en", 32'(dec_en), 32'd1);
    check_value("single_gnt", 32'(gnt_n), 32'hF7);
    cycle(8'h08, 1'b0);
    cycle(8'h00, 1'b0);
    check_value("drop_gnt", 32'(gnt_n), 32'hFF);
    check_value("drop_busy", 32'(busy), 32'd1);
    for (int i = 1; i < GAP; i++) cycle(8'h00, 1'b0);
    cycle(8'h00, 1'b0);
    check_value("idle_busy", 32'(busy), 32'd0);

    // 3. fairness between requesters 0 and 7
    cycle(8'h00, 1'b1);
    exp_q = '{8'd0, 8'd7, 8'd0, 8'd7};
    grants = 0; dis_cycles = 0; budget = 60;
    while (grants < 4 && budget > 0) begin
      r = 8'h81;
      if (m_owner >= 0 && m_hold == 2) r[m_owner] = 1'b0;
      begin
        logic pe;
        pe = p_dec_en;
        cycle(r, 1'b0);
        if (dec_en && !pe) begin
          if (grants < 4) check_value("fair_order", 32'(owner_of(gnt_n)), 32'(exp_q[grants]));
          grants++;
        end else if (!dec_en && grants > 0) begin
          dis_cycles++;
        end
      end
      budget--;
    end
    check_value("fair_grants", 32'(grants), 32'd4);
    check_value("fair_gap_total", 32'(dis_cycles), 32'(3 * GAP));
    drain();

    // 4. wrap-around of the priority pointer
    cycle(8'h00, 1'b1);
    cycle(8'h40, 1'b0);
    check_value("wrap_g6", 32'(gnt_n), 32'hBF);
    drain();
    cycle(8'h03, 1'b0);
    check_value("wrap_g0", 32'(gnt_n), 32'hFE);
    drain();
    cycle(8'h03, 1'b0);
    check_value("wrap_g1", 32'(gnt_n), 32'hFD);
    drain();
    cycle(8'h40, 1'b0);
    check_value("wrap_g6b", 32'(gnt_n), 32'hBF);
    drain();

    // 5. reset in the middle of a grant
    cycle(8'h20, 1'b0);
    check_value("mid_g5", 32'(sel), 32'd5);
    cycle(8'h20, 1'b1);
    check_value("mid_rst_gnt", 32'(gnt_n), 32'hFF);
    check_value("mid_rst_en", 32'(dec_en), 32'd0);
    check_value("mid_rst_sel", 32'(sel), 32'd0);
    cycle(8'h20, 1'b0);
    check_value("mid_regrant", 32'(gnt_n), 32'hDF);
    drain();

    // 6. long hold on a single requester
    to_pulses = 0; grants = 0;
    for (int i = 0; i < 40; i++) begin
      logic pe;
      pe = p_dec_en;
      cycle(8'h20, 1'b0);
      if (hold_timeout) to_pulses++;
      if (dec_en && !pe) grants++;
    end
    check_value("hold_pulses", 32'(to_pulses), TO_EN ? 32'd2 : 32'd0);
    check_value("hold_grants", 32'(grants), TO_EN ? 32'd3 : 32'd1);
    drain();

    // 7. randomized traffic
    r = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0)
        r = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
      cycle(r, ($urandom_range(0, 149) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
